// File: rtl/wrd_pkg.sv
// ----------------------------------------------------------------------------
// wrd_pkg
//   Shared definitions for the wrd vector datapath. The packer (vec_pack) and
//   the vector reduction stage (red_add) agree on the lane width and the lane
//   count through these defaults.
//
//   Contents:
//     I_BW_DEF        default width of one signed scalar / vector lane
//     VECTOR_LEN_DEF  default lanes per packed vector
//     cnt_bw()        width needed to hold a lane count 0..VECTOR_LEN
//     idx_bw()        width of a lane index 0..VECTOR_LEN-1 (at least 1 bit)
//     lane_lo()       LSB position of lane k inside a packed vector
// ----------------------------------------------------------------------------
package wrd_pkg;

    localparam int I_BW_DEF       = 18;
    localparam int VECTOR_LEN_DEF = 2;

    function automatic int cnt_bw(input int vlen);
        return $clog2(vlen + 1);
    endfunction

    // A one-lane vector still needs a 1-bit index register.
    function automatic int idx_bw(input int vlen);
        return (vlen > 1) ? $clog2(vlen) : 1;
    endfunction

    // Lane k occupies [(k+1)*bw-1 : k*bw]; lane 0 sits in the LSBs.
    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/vec_pack.sv
// ----------------------------------------------------------------------------
// vec_pack
//   Streaming scalar-to-vector packer. Successive signed scalars are collected
//   into a lane buffer; a packed vector is emitted after VECTOR_LEN accepted
//   beats, or earlier when last_i closes a partial group. Lanes above the last
//   populated one are driven to zero.
//
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_i    in   synchronous reset, active-high
//     data_i   in   [I_BW-1:0] signed scalar
//     valid_i  in   input beat valid
//     last_i   in   input beat is the last of its frame
//     ready_o  out  packer can take a beat this cycle
//     data_o   out  [VECTOR_LEN*I_BW-1:0] packed vector, lane k at k*I_BW
//     valid_o  out  output vector valid
//     last_o   out  vector carries the frame's final element
//     cnt_o    out  [CNT_BW-1:0] populated lanes (1..VECTOR_LEN)
//     ready_i  in   downstream takes the vector this cycle
//
//   Handshake: a beat moves when valid_x & ready_x are both high at a rising
//   edge. While valid_o & !ready_i the output vector, cnt_o and last_o hold.
//   ready_o depends on ready_i and the output register only, never on the
//   input-side valid/data/last.
// ----------------------------------------------------------------------------
module vec_pack
    import wrd_pkg::*;
#(
    parameter  int I_BW       = I_BW_DEF,
    parameter  int VECTOR_LEN = VECTOR_LEN_DEF,
    localparam int CNT_BW     = cnt_bw(VECTOR_LEN)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [I_BW-1:0]            data_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic                       ready_o,
    output logic [VECTOR_LEN*I_BW-1:0] data_o,
    output logic                       valid_o,
    output logic                       last_o,
    output logic [CNT_BW-1:0]          cnt_o,
    input  logic                       ready_i
);

    localparam int                IDX_BW  = idx_bw(VECTOR_LEN);
    localparam int                VEC_BW  = VECTOR_LEN * I_BW;
    localparam logic [IDX_BW-1:0] IDX_MAX = IDX_BW'(VECTOR_LEN - 1);

    logic [IDX_BW-1:0] idx_q;
    logic [IDX_BW-1:0] idx_d;
    logic [I_BW-1:0]   lane_q [VECTOR_LEN];
    logic [VEC_BW-1:0] vec_d;
    logic [VEC_BW-1:0] data_q;
    logic [CNT_BW-1:0] cnt_q;
    logic              valid_q;
    logic              last_q;

    logic accept;
    logic complete;

    // The output register is free when empty or being drained this cycle,
    // which lets a completing beat reload it with no bubble.
    assign ready_o  = !valid_q || ready_i;
    assign accept   = valid_i && ready_o;
    assign complete = accept && ((idx_q == IDX_MAX) || last_i);

    always_comb begin
        idx_d = idx_q;
        if (complete) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + IDX_BW'(1);
        end
    end

    // Next output vector: buffered lanes below idx, the incoming scalar at
    // idx, zeros above. Only meaningful on a completing beat.
    for (genvar k = 0; k < VECTOR_LEN; k++) begin : g_lane
        localparam logic [IDX_BW-1:0] K = IDX_BW'(k);
        assign vec_d[lane_lo(k, I_BW) +: I_BW] =
            (K < idx_q)  ? lane_q[k] :
            (K == idx_q) ? data_i    : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int k = 0; k < VECTOR_LEN; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            idx_q <= idx_d;

            // The buffer is wiped when a group closes so a short group never
            // leaves stale lanes behind for the next one.
            for (int k = 0; k < VECTOR_LEN; k++) begin
                if (complete) begin
                    lane_q[k] <= '0;
                end else if (accept && (idx_q == IDX_BW'(k))) begin
                    lane_q[k] <= data_i;
                end
            end

            if (complete) begin
                data_q  <= vec_d;
                cnt_q   <= CNT_BW'(idx_q) + CNT_BW'(1);
                last_q  <= last_i;
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign cnt_o   = cnt_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule
